// File: rtl/spi_master_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_engine
// Description : Parametrised SPI master. Shifts one DATA_WIDTH-bit word per
//               transaction with per-transaction CPOL/CPHA. It drives NUM_CS
//               active-low chip selects, and chip select can be held low
//               across words for burst transfers.
// Optional    : SPI_MASTER_LSB_FIRST_EN adds the lsb_first input. When it is
//               latched high, mosi and miso shift LSB first. Without the
//               macro, all transfers are MSB first.
// Ports       : clk, reset         - clock, async active-high reset
//               start              - transfer request (ignored while busy)
//               data_in            - word to transmit
//               cs_select          - chip-select index (held across a burst)
//               cpol, cpha         - SPI mode (held across a burst)
//               keep_cs            - keep CS low after this word (HOLD)
//               cs_release         - leave HOLD and deassert CS
//               miso               - serial input
//               data_out           - last received word
//               data_valid         - one-cycle pulse on data_out update
//               busy               - transfer in progress
//               cs_n, sck, mosi    - SPI bus outputs
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_engine #(
  parameter int DATA_WIDTH  = 8,
  parameter int CLK_DIVIDER = 1,
  parameter int NUM_CS      = 1,
  localparam int CSW        = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [CSW-1:0]        cs_select,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  keep_cs,
  input  logic                  cs_release,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic                  lsb_first,
`endif
  input  logic                  miso,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic [NUM_CS-1:0]     cs_n,
  output logic                  sck,
  output logic                  mosi
);

  localparam int TW  = (CLK_DIVIDER > 1) ? $clog2(CLK_DIVIDER) : 1;
  localparam int ECW = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [TW-1:0]  TMAX      = TW'(CLK_DIVIDER - 1);
  localparam logic [ECW-1:0] LAST_EDGE = ECW'(2 * DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  state_t                state_q;
  logic [TW-1:0]         timer_q;
  logic [ECW-1:0]        edge_q;
  logic [DATA_WIDTH-1:0] tx_q;
  logic [DATA_WIDTH-1:0] rx_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  data_valid_q;
  logic                  busy_q;
  logic [NUM_CS-1:0]     cs_n_q;
  logic                  sck_q;
  logic                  mosi_q;
  logic [CSW-1:0]        cs_sel_q;
  logic                  cpol_q;
  logic                  cpha_q;
  logic                  keep_q;

  // Bit order: the value used at accept comes from the port, while the value
  // used during the shift comes from the latched copy.
  logic w_lsb_acc;
  logic w_lsb_cur;
`ifdef SPI_MASTER_LSB_FIRST_EN
  logic lsb_q;
  assign w_lsb_acc = lsb_first;
  assign w_lsb_cur = lsb_q;
`else
  assign w_lsb_acc = 1'b0;
  assign w_lsb_cur = 1'b0;
`endif

  logic                  w_half_done;
  logic                  w_accept;
  logic                  w_from_hold;
  logic [CSW-1:0]        w_sel;
  logic                  w_cpol;
  logic                  w_cpha;
  logic                  w_sample;
  logic [NUM_CS-1:0]     w_cs_dec;

  assign w_half_done = (timer_q == TMAX);
  assign w_from_hold = (state_q == ST_HOLD);
  assign w_accept    = start && !busy_q && ((state_q == ST_IDLE) || w_from_hold);

  // A burst continued from HOLD reuses the held mode and chip select.
  assign w_sel  = w_from_hold ? cs_sel_q : cs_select;
  assign w_cpol = w_from_hold ? cpol_q   : cpol;
  assign w_cpha = w_from_hold ? cpha_q   : cpha;

  // Even edge counts are leading SCK edges. Sampling happens on leading edges
  // for cpha=0 and on trailing edges for cpha=1.
  assign w_sample = (edge_q[0] == cpha_q);

  // One-hot active-low decode. An out-of-range index matches no output.
  for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
    assign w_cs_dec[gi] = (w_sel != CSW'(gi));
  end

  function automatic logic next_bit(input logic [DATA_WIDTH-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] tx_shift(input logic [DATA_WIDTH-1:0] v,
                                                     input logic lsb);
    return lsb ? {1'b0, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rx_insert(input logic [DATA_WIDTH-1:0] v,
                                                      input logic b, input logic lsb);
    return lsb ? {b, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], b};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      edge_q       <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      cs_n_q       <= '1;
      sck_q        <= 1'b0;
      mosi_q       <= 1'b1;
      cs_sel_q     <= '0;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      keep_q       <= 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
      lsb_q        <= 1'b0;
`endif
    end else begin
      data_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          timer_q <= '0;
          sck_q   <= cpol_q;
          if (w_accept) begin
            state_q <= ST_SETUP;
            busy_q  <= 1'b1;
            edge_q  <= '0;
            keep_q  <= keep_cs;
            cs_n_q  <= w_cs_dec;
            sck_q   <= w_cpol;
`ifdef SPI_MASTER_LSB_FIRST_EN
            lsb_q   <= lsb_first;
`endif
            if (!w_from_hold) begin
              cs_sel_q <= cs_select;
              cpol_q   <= cpol;
              cpha_q   <= cpha;
            end
            // With cpha=0 the first bit must be on the wire before the first
            // leading edge, so it is driven on SETUP entry.
            if (!w_cpha) begin
              mosi_q <= next_bit(data_in, w_lsb_acc);
              tx_q   <= tx_shift(data_in, w_lsb_acc);
            end else begin
              tx_q   <= data_in;
            end
          end else if (w_from_hold && cs_release) begin
            cs_n_q  <= '1;
            state_q <= ST_IDLE;
          end
        end

        ST_SETUP: begin
          if (w_half_done) begin
            timer_q <= '0;
            state_q <= ST_SHIFT;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        ST_SHIFT: begin
          if (w_half_done) begin
            timer_q <= '0;
            sck_q   <= ~sck_q;
            edge_q  <= edge_q + 1'b1;
            if (w_sample) begin
              rx_q <= rx_insert(rx_q, miso, w_lsb_cur);
            end else if (edge_q != LAST_EDGE) begin
              mosi_q <= next_bit(tx_q, w_lsb_cur);
              tx_q   <= tx_shift(tx_q, w_lsb_cur);
            end
            // An even number of toggles leaves sck back at cpol.
            if (edge_q == LAST_EDGE) begin
              state_q <= ST_DONE;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        ST_DONE: begin
          if (w_half_done) begin
            timer_q      <= '0;
            data_out_q   <= rx_q;
            data_valid_q <= 1'b1;
            busy_q       <= 1'b0;
            if (keep_q) begin
              state_q <= ST_HOLD;
            end else begin
              cs_n_q  <= '1;
              state_q <= ST_IDLE;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign cs_n       = cs_n_q;
  assign sck        = sck_q;
  assign mosi       = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_engine
// Description : Self-checking bench for spi_master_engine. It runs a vector
//               table of directed transfers, hand-written burst/reset/busy
//               sequences and randomized transfers, all against a
//               behavioural SPI slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_engine;

  localparam int N   = 8;
  localparam int D   = 2;
  localparam int NCS = 4;
  localparam int LAT = (2 * N + 2) * D + 1;

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] data_in;
  logic [1:0]   cs_select;
  logic         cpol;
  logic         cpha;
  logic         keep_cs;
  logic         cs_release;
`ifdef SPI_MASTER_LSB_FIRST_EN
  logic         lsb_first;
`endif
  logic         miso;
  logic [N-1:0] data_out;
  logic         data_valid;
  logic         busy;
  logic [NCS-1:0] cs_n;
  logic         sck;
  logic         mosi;

  spi_master_engine #(
    .DATA_WIDTH (N),
    .CLK_DIVIDER(D),
    .NUM_CS     (NCS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data_in   (data_in),
    .cs_select (cs_select),
    .cpol      (cpol),
    .cpha      (cpha),
    .keep_cs   (keep_cs),
    .cs_release(cs_release),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first (lsb_first),
`endif
    .miso      (miso),
    .data_out  (data_out),
    .data_valid(data_valid),
    .busy      (busy),
    .cs_n      (cs_n),
    .sck       (sck),
    .mosi      (mosi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int dv_count = 0;

  always @(posedge clk) if (data_valid === 1'b1) dv_count++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural SPI slave ----------------
  logic         loopback = 1'b1;
  logic         slave_en = 1'b0;
  logic         slave_rst = 1'b0;
  logic         s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0;
  logic [N-1:0] s_resp = '0;
  logic [N-1:0] s_seq;       // mosi bits in time order, first bit at MSB
  logic         s_miso;
  int           s_out;
  int           s_rises;

  function automatic logic bit_at(input logic [N-1:0] w, input logic lsb, input int i);
    return lsb ? w[i] : w[N-1-i];
  endfunction

  function automatic logic [N-1:0] rev(input logic [N-1:0] w);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = w[N-1-i];
    return r;
  endfunction

  always @(sck or posedge slave_rst) begin
    if (slave_rst) begin
      s_seq   = '0;
      s_rises = 0;
      if (!s_cpha) begin
        s_miso = bit_at(s_resp, s_lsb, 0);
        s_out  = 1;
      end else begin
        s_miso = 1'b0;
        s_out  = 0;
      end
    end else if (slave_en) begin
      if (sck === 1'b1) s_rises++;
      // Leading edge leaves the idle level. cpha=0 samples on leading edges.
      if ((sck !== s_cpol) == (s_cpha == 1'b0)) begin
        s_seq = {s_seq[N-2:0], mosi};
      end else if (s_out < N) begin
        s_miso = bit_at(s_resp, s_lsb, s_out);
        s_out++;
      end
    end
  end

  assign miso = loopback ? mosi : s_miso;

  // ---------------- one word transfer with checks ----------------
  logic g_rel = 1'b0;  // drive cs_release together with start

  task automatic xfer(input logic [N-1:0] din, input logic c_pol, input logic c_pha,
                      input logic [1:0] sel, input logic keep, input logic lb,
                      input logic [N-1:0] resp, input logic lsb,
                      input logic [NCS-1:0] exp_csn, input logic [N-1:0] exp_dout,
                      input int poke);
    int k;
    logic csn_bad;
    logic [N-1:0] exp_seq;
    exp_seq = lsb ? rev(din) : din;
    @(negedge clk);
    slave_en   = 1'b0;
    data_in    = din;
    cpol       = c_pol;
    cpha       = c_pha;
    cs_select  = sel;
    keep_cs    = keep;
    cs_release = g_rel;
`ifdef SPI_MASTER_LSB_FIRST_EN
    lsb_first  = lsb;
`endif
    loopback   = lb;
    s_cpol     = c_pol;
    s_cpha     = c_pha;
    s_lsb      = lsb;
    s_resp     = resp;
    slave_rst  = 1'b1;
    #1 slave_rst = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    cs_release = 1'b0;
    slave_en   = 1'b1;
    chk("busy_cycle1", {31'd0, busy}, 32'd1);
    k = 1;
    csn_bad = 1'b0;
    while (data_valid !== 1'b1 && k < 100) begin
      if (cs_n !== exp_csn) csn_bad = 1'b1;
      if (poke != 0 && k == poke) begin
        start   = 1'b1;
        data_in = '1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk("valid_latency", k, LAT);
    chk("data_out", {24'd0, data_out}, {24'd0, exp_dout});
    chk("busy_at_valid", {31'd0, busy}, 32'd0);
    chk("cs_n_during", {31'd0, csn_bad}, 32'd0);
    chk("cs_n_after", {28'd0, cs_n}, {28'd0, (keep ? exp_csn : 4'b1111)});
    chk("sck_rises", s_rises, N);
    chk("slave_rx", {24'd0, s_seq}, {24'd0, exp_seq});
    chk("sck_idle", {31'd0, sck}, {31'd0, c_pol});
    @(negedge clk);
    chk("valid_pulse_end", {30'd0, data_valid, busy}, 32'd0);
  endtask

  typedef struct {
    logic [N-1:0]   din;
    logic           cpol;
    logic           cpha;
    logic [1:0]     sel;
    logic           lb;
    logic [N-1:0]   resp;
    logic [NCS-1:0] exp_csn;
    logic [N-1:0]   exp_dout;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int dv0;
    logic [N-1:0] rd, rr;
    logic [1:0]   rs;
    logic         rp, rh, rl, rlsb;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 2'd0, 1'b1, 8'h00, 4'b1110, 8'hA5};  // mode 0 loopback
    vecs[1] = '{8'h81, 1'b1, 1'b1, 2'd0, 1'b0, 8'h3C, 4'b1110, 8'h3C};  // mode 3 slave
    vecs[2] = '{8'hC3, 1'b0, 1'b1, 2'd1, 1'b0, 8'h5A, 4'b1101, 8'h5A};  // mode 1
    vecs[3] = '{8'h7E, 1'b1, 1'b0, 2'd3, 1'b1, 8'h00, 4'b0111, 8'h7E};  // mode 2

    reset = 1'b1; start = 1'b0; data_in = '0; cs_select = '0; cpol = 1'b0;
    cpha = 1'b0; keep_cs = 1'b0; cs_release = 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
    lsb_first = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_cs_n", {28'd0, cs_n}, 32'hF);
    chk("rst_sck", {31'd0, sck}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd1);
    chk("rst_busy_valid", {30'd0, busy, data_valid}, 32'd0);
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++)
      xfer(vecs[i].din, vecs[i].cpol, vecs[i].cpha, vecs[i].sel, 1'b0, vecs[i].lb,
           vecs[i].resp, 1'b0, vecs[i].exp_csn, vecs[i].exp_dout, 0);

    // Burst on CS 2; the second word's cs_select input must be ignored.
    dv0 = dv_count;
    xfer(8'h11, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 8'h00, 1'b0, 4'b1011, 8'h11, 0);
    xfer(8'h22, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 8'h00, 1'b0, 4'b1011, 8'h22, 0);
    chk("burst_pulses", dv_count - dv0, 2);

    // Burst ended by cs_release.
    xfer(8'h11, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 8'h00, 1'b0, 4'b1011, 8'h11, 0);
    cs_release = 1'b1;
    #1 chk("hold_before_release", {28'd0, cs_n}, 32'hB);
    @(negedge clk);
    cs_release = 1'b0;
    chk("cs_release", {28'd0, cs_n}, 32'hF);

    // start and cs_release together in HOLD: start wins.
    xfer(8'h33, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 8'hC6, 1'b0, 4'b1101, 8'hC6, 0);
    g_rel = 1'b1;
    xfer(8'h44, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 8'h9B, 1'b0, 4'b1101, 8'h9B, 0);
    g_rel = 1'b0;

    // Start while busy is ignored.
    xfer(8'h5A, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 8'h00, 1'b0, 4'b1110, 8'h5A, 5);

    // Reset at cycle 10 of a transfer.
    @(negedge clk);
    slave_en = 1'b0; loopback = 1'b1;
    data_in = 8'h00; cpol = 1'b1; cpha = 1'b0; cs_select = 2'd1; keep_cs = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    dv0 = dv_count;
    reset = 1'b1;
    #1;
    chk("midrst_cs_n", {28'd0, cs_n}, 32'hF);
    chk("midrst_sck_mosi", {30'd0, sck, mosi}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (LAT + 5) @(negedge clk);
    chk("midrst_no_valid", dv_count - dv0, 0);
    xfer(8'h96, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 8'h00, 1'b0, 4'b1110, 8'h96, 0);

`ifdef SPI_MASTER_LSB_FIRST_EN
    xfer(8'h01, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 8'h00, 1'b1, 4'b1110, 8'h01, 0);
    xfer(8'h2D, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 8'hB1, 1'b1, 4'b1011, 8'hB1, 0);
`endif

    // Randomized transfers against the reference rules.
    for (int i = 0; i < 12; i++) begin
      rd   = N'($urandom);
      rr   = N'($urandom);
      rs   = 2'($urandom_range(0, 3));
      rp   = 1'($urandom);
      rh   = 1'($urandom);
      rl   = 1'($urandom);
      rlsb = 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
      rlsb = 1'($urandom);
`endif
      xfer(rd, rp, rh, rs, 1'b0, rl, rr, rlsb, ~(4'b0001 << rs), (rl ? rd : rr), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_master_engine.md
# spi_master_engine

Parametrised SPI master that shifts one DATA_WIDTH-bit word per transaction and drives NUM_CS active-low chip selects. SPI mode (CPOL/CPHA) is selected per transaction. Chip select can be held low across consecutive words for burst transfers. It sits between a register or command FSM and off-chip SPI peripherals (flash, sensors, displays), in place of the fixed 8-bit mode-0 master.

## Interface
Parameters:
- DATA_WIDTH, 8: bits per word, ≥2
- CLK_DIVIDER, 1: clk cycles per SCK half-period, ≥1
- NUM_CS, 1: number of chip-select outputs, ≥1

Ports (CSW = max(1, $clog2(NUM_CS))):
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; returns the block to IDLE immediately
- start  in  1  request a word transfer; sampled only while busy=0
- data_in  in  DATA_WIDTH  word to transmit; latched on accept
- cs_select  in  CSW  chip-select index; latched on accept from IDLE
- cpol  in  1  SCK idle level; latched on accept from IDLE
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on accept from IDLE
- keep_cs  in  1  latched on accept; 1 = hold CS low after this word
- cs_release  in  1  in HOLD, deasserts CS and returns to IDLE
- miso  in  1  serial data from the slave
- data_out  out  DATA_WIDTH  last received word
- data_valid  out  1  one-cycle pulse when data_out updates
- busy  out  1  transfer in progress
- cs_n  out  NUM_CS  active-low chip selects
- sck  out  1  serial clock
- mosi  out  1  serial data to the slave

## Operation
- Reset values: cs_n = all ones, sck = 0, mosi = 1, busy = 0, data_valid = 0, data_out = 0. State is IDLE.
- **Accept:** start=1 with busy=0 in IDLE or HOLD at a clk edge. Latches the inputs, zeroes the divider timer, and sets busy=1 the next cycle. start while busy=1 is ignored.
- **States:** IDLE, SETUP, SHIFT, DONE, HOLD.
- **IDLE:**
  - sck follows the registered cpol every cycle.
  - On accept, go to SETUP.
- **SETUP** (1 half-period):
  - cs_n[cs_select] = 0.
  - sck = cpol.
  - If cpha=0, mosi = first bit.
  - Then go to SHIFT.
- **SHIFT:**
  - 2·DATA_WIDTH SCK edges, one every CLK_DIVIDER cycles.
  - cpha=0: sample miso on the leading edge; drive the next bit on the trailing edge, except after the last bit.
  - cpha=1: drive a bit on the leading edge; sample miso on the trailing edge.
  - After the final edge, sck = cpol. Go to DONE.
- **DONE** (1 half-period, CS hold time), then:
  - data_out = shift register.
  - data_valid = 1 for one cycle.
  - busy = 0.
  - If keep_cs is latched high, go to HOLD with cs_n unchanged. Otherwise drive cs_n all ones and go to IDLE.
- **HOLD:**
  - busy = 0, cs_n stays low, sck = cpol.
  - On start, go to SETUP, reusing the held cs_select, cpol and cpha (the inputs are ignored). data_in and keep_cs are re-latched.
  - If cs_release=1 and start=0, drive cs_n all ones and go to IDLE next cycle.
  - If start and cs_release are both 1, start wins.
- **Out-of-range cs_select** (≥ NUM_CS): the transfer runs normally with no cs_n asserted.
- **Reset mid-transfer:** asynchronously forces the reset values. The partial word is discarded and data_valid is not pulsed.

## Timing
- Accepting edge = cycle 0. busy=1 from cycle 1.
- data_valid=1 and busy=0 in cycle (2·DATA_WIDTH+2)·CLK_DIVIDER + 1.
- Minimum cycles between accepts: (2·DATA_WIDTH+2)·CLK_DIVIDER + 1.
- SCK edges are exactly CLK_DIVIDER clk cycles apart. SCK duty cycle is 50%.
- mosi changes only on SCK edges or on SETUP entry.
- miso is sampled on the clk edge that produces the sampling SCK edge.

## Configuration
- Macro: SPI_MASTER_LSB_FIRST_EN.
- **Defined:** adds input port lsb_first (1 bit), latched on accept. When 1, both mosi and miso shift LSB first; when 0, MSB first.
- **Undefined:** the port is absent and all transfers are MSB first.

## Test plan
- **Mode 0 loopback.** DATA_WIDTH=8, CLK_DIVIDER=2, cpol=0, cpha=0, miso tied to mosi, data_in=0xA5, cs_select=0. Required: 8 rising sck edges, data_out=0xA5, data_valid in cycle 37, cs_n[0] high again in that cycle.
- **Mode 3.** Slave model returns 0x3C; cpol=1, cpha=1, data_in=0x81. Required: sck idles high, the slave captures 0x81, data_out=0x3C.
- **Burst.** NUM_CS=4, cs_select=2. Send 0x11 with keep_cs=1, then 0x22 with keep_cs=0. Required: cs_n=4'b1011 continuously from the first SETUP to the second DONE, two data_valid pulses, cs_n=4'b1111 after the second. Repeat with cs_release after the first word: cs_n returns to 4'b1111 one cycle after cs_release.
- **Reset mid-transfer.** Assert reset at cycle 10 of a transfer. Required: cs_n, sck, mosi and busy take their reset values in the same cycle. No data_valid pulse. A new start then completes normally.
- **Start while busy.** Pulse start with data_in=0xFF at cycle 5 of a 0x5A transfer. Required: it is ignored; only 0x5A is shifted out.
- **LSB first.** With SPI_MASTER_LSB_FIRST_EN defined, lsb_first=1 and data_in=0x01. Required: mosi is 1 on the first bit and 0 afterwards; a loopback gives data_out=0x01.
